// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver: double-buffered BCD word, per-digit
// time slots with leading blanking, optional leading-zero suppression.
module seg7_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_bcd,
    input  logic [DIGITS-1:0]     load_dp,
    input  logic                  lz_blank,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  frame_done
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   active_bcd;
    logic [DIGITS-1:0]     active_dp;
    logic [4*DIGITS-1:0]   pend_bcd;
    logic [DIGITS-1:0]     pend_dp;
    logic                  pend_full;

    logic                  slot_end;
    logic                  last_digit;
    logic                  frame_end;
    logic                  in_blank;
    logic                  accept;

    logic [3:0]            nib_p0;
    logic                  dp_p0;
    logic [DIGITS-1:0]     en_p0;
    logic                  lz_p0;
    logic [DIGITS-1:0]     lz_mask;
    logic                  zero_run;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h40;
        endcase
    endfunction

    assign slot_end   = (presc == PW'(REFRESH_DIV - 1));
    assign last_digit = (idx == IW'(DIGITS - 1));
    assign frame_end  = slot_end && last_digit;
    assign in_blank   = (int'(presc) < BLANK_CYCLES);
    assign load_ready = !pend_full && !rst;
    assign accept     = load_valid && load_ready;

    // A digit is a leading zero when it and every digit above it is zero.
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run && (active_bcd[4*i +: 4] == 4'd0);
            lz_mask[i] = zero_run;
        end
    end

    // Stage p0: select the digit addressed by the current slot
    always_comb begin
        nib_p0 = '0;
        dp_p0  = 1'b0;
        en_p0  = '0;
        lz_p0  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib_p0   = active_bcd[4*i +: 4];
                dp_p0    = active_dp[i];
                en_p0[i] = 1'b1;
                lz_p0    = lz_blank && lz_mask[i];
            end
        end
    end

    // Stage p1: registered scan state, buffers and display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            idx        <= '0;
            active_bcd <= '0;
            active_dp  <= '0;
            pend_bcd   <= '0;
            pend_dp    <= '0;
            pend_full  <= 1'b0;
            seg_out    <= '0;
            dp_out     <= 1'b0;
            dig_en     <= '0;
            frame_done <= 1'b0;
        end else begin
            if (slot_end) begin
                presc <= '0;
                idx   <= last_digit ? '0 : idx + IW'(1);
            end else begin
                presc <= presc + PW'(1);
            end

            // Swap and accept are exclusive: accept needs an empty pending slot.
            if (frame_end && pend_full) begin
                active_bcd <= pend_bcd;
                active_dp  <= pend_dp;
                pend_full  <= 1'b0;
            end else if (accept) begin
                pend_bcd  <= load_bcd;
                pend_dp   <= load_dp;
                pend_full <= 1'b1;
            end

            frame_done <= frame_end;
            if (in_blank) begin
                dig_en  <= '0;
                seg_out <= '0;
                dp_out  <= 1'b0;
            end else begin
                dig_en  <= en_p0;
                seg_out <= lz_p0 ? 7'h00 : seg_decode(nib_p0);
                dp_out  <= dp_p0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (4 digits, 8-cycle slots, 2 blank cycles):
// directed scenarios plus random loads against a cycle-count reference model.
module tb_seg7_scan_driver;

    localparam int DIGITS = 4;
    localparam int RDIV   = 8;
    localparam int BLANK  = 2;
    localparam int FRAME  = RDIV * DIGITS;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_bcd;
    logic [3:0]  load_dp;
    logic        lz_blank;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  dig_en;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    // Reference model state: cycles since reset release plus the two buffers.
    int          t;
    logic [15:0] m_act;
    logic [3:0]  m_act_dp;
    logic [15:0] m_pend;
    logic [3:0]  m_pend_dp;
    bit          m_full;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DIGITS(DIGITS),
        .REFRESH_DIV(RDIV),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_bcd(load_bcd),
        .load_dp(load_dp),
        .lz_blank(lz_blank),
        .seg_out(seg_out),
        .dp_out(dp_out),
        .dig_en(dig_en),
        .frame_done(frame_done)
    );

    function automatic logic [6:0] ref_seg(input int n);
        logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (n > 9) return 7'h40;
        return tbl[n];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic step();
        int         ph;
        int         d;
        int         nib;
        bit         acc;
        bit         e_fd;
        logic [6:0] e_seg;
        logic       e_dp;
        logic [3:0] e_en;
        e_seg = '0;
        e_dp  = 1'b0;
        e_en  = '0;
        e_fd  = 1'b0;
        if (!rst) begin
            ph   = t % RDIV;
            d    = (t / RDIV) % DIGITS;
            e_fd = ((t % FRAME) == FRAME - 1);
            if (ph >= BLANK) begin
                e_en = 4'(1 << d);
                nib  = int'((m_act >> (4 * d)) & 16'h000F);
                if (lz_blank && d != 0 && (m_act >> (4 * d)) == 16'h0000)
                    e_seg = 7'h00;
                else
                    e_seg = ref_seg(nib);
                e_dp = m_act_dp[d];
            end
        end
        acc = load_valid && !m_full && !rst;
        @(posedge clk);
        #1;
        if (rst) begin
            t         = 0;
            m_act     = '0;
            m_act_dp  = '0;
            m_pend    = '0;
            m_pend_dp = '0;
            m_full    = 1'b0;
        end else begin
            if (e_fd && m_full) begin
                m_act    = m_pend;
                m_act_dp = m_pend_dp;
                m_full   = 1'b0;
            end else if (acc) begin
                m_pend    = load_bcd;
                m_pend_dp = load_dp;
                m_full    = 1'b1;
            end
            t++;
        end
        check("seg_out", 32'(seg_out), 32'(e_seg));
        check("dig_en", 32'(dig_en), 32'(e_en));
        check("dp_out", 32'(dp_out), 32'(e_dp));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("load_ready", 32'(load_ready), 32'(!m_full && !rst));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_word(input logic [15:0] b, input logic [3:0] p);
        int k;
        k          = 0;
        load_valid = 1'b1;
        load_bcd   = b;
        load_dp    = p;
        while (!load_ready && k < 100) begin
            step();
            k++;
        end
        check("load_accept_wait", 32'(load_ready), 32'd1);
        step();
        load_valid = 1'b0;
    endtask

    initial begin
        t          = 0;
        m_act      = '0;
        m_act_dp   = '0;
        m_pend     = '0;
        m_pend_dp  = '0;
        m_full     = 1'b0;
        rst        = 1'b1;
        load_valid = 1'b0;
        load_bcd   = '0;
        load_dp    = '0;
        lz_blank   = 1'b0;

        // Reset state, then edges 1..4 of idle scanning
        run(2);
        rst = 1'b0;
        run(4);

        // Load 0x1234 dp=0100 presented at edge 5; visible from frame 2
        load_word(16'h1234, 4'b0100);
        run(80);

        // Back-to-back loads: second waits for the next frame boundary
        load_word(16'h1111, 4'b0000);
        load_word(16'h2222, 4'b0001);
        run(100);

        // Leading-zero suppression on 0x0070 and on all zeros
        lz_blank = 1'b1;
        load_word(16'h0070, 4'b0000);
        run(80);
        load_word(16'h0000, 4'b1000);
        run(80);

        // Non-BCD code shows a dash
        lz_blank = 1'b0;
        load_word(16'h00C0, 4'b0000);
        run(80);

        // Mid-operation reset discards a pending word
        load_word(16'h9876, 4'b1111);
        run(5);
        load_word(16'h5555, 4'b0101);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(70);

        // Random traffic with handshake-respecting data holds
        for (int i = 0; i < 900; i++) begin
            if (!load_valid || load_ready) begin
                load_valid = ($urandom % 4) == 0;
                for (int j = 0; j < DIGITS; j++)
                    load_bcd[4*j +: 4] = (($urandom % 8) < 3) ? 4'd0 : 4'($urandom % 16);
                load_dp = 4'($urandom % 16);
            end
            if ((i % 16) == 0) lz_blank = 1'($urandom % 2);
            if (i == 500) rst = 1'b1;
            if (i == 502) rst = 1'b0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
